qcpu_spi_arbiter: RTL

- Controller that shares one qcpu_spi byte engine between two requesters, e.g. port 0 = boot/flash fetch and port 1 = CPU SPI peripheral register.
- Grants the engine round-robin and drives one active-low chip select per requester, held across multi-byte transactions.
- Sequences the engine's start/busy handshake and returns each received byte with a one-cycle done pulse.
- Sits between the requesters and qcpu_spi; the SCLK, DO and DI pins stay on qcpu_spi.

---
 rtl/qcpu_spi_pkg.sv | 16 +
 rtl/qcpu_spi_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/qcpu_spi_pkg.sv
// rtl/qcpu_spi_pkg.sv - shared state encoding and timing defaults for the qcpu_spi arbiter
package qcpu_spi_pkg;

  // Arbiter FSM state encoding
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETUP   = 3'd1;
  localparam logic [2:0] ST_READY   = 3'd2;
  localparam logic [2:0] ST_WAIT_HI = 3'd3;
  localparam logic [2:0] ST_WAIT_LO = 3'd4;
  localparam logic [2:0] ST_GUARD   = 3'd5;

  // Default chip-select setup and guard times, in clocks
  localparam int DEF_SETUP_CYC = 2;
  localparam int DEF_GUARD_CYC = 2;

endpackage

// File: rtl/qcpu_spi_arbiter.sv
// rtl/qcpu_spi_arbiter.sv - round-robin sharing of one qcpu_spi byte engine between two requesters
module qcpu_spi_arbiter
  import qcpu_spi_pkg::*;
#(
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int GUARD_CYC = DEF_GUARD_CYC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic       xfer0,
  input  logic       xfer1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  input  logic [7:0] div0,
  input  logic [7:0] div1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done,
  output logic [7:0] rdata,
  output logic       cs0_n,
  output logic       cs1_n,
  output logic       spi_start,
  output logic [7:0] spi_din,
  output logic [7:0] spi_divisor,
  input  logic       spi_busy,
  input  logic [7:0] spi_dout
);

  localparam logic [3:0] SETUP_LOAD = 4'(SETUP_CYC - 1);
  localparam logic [3:0] GUARD_LOAD = 4'(GUARD_CYC - 1);

  logic [2:0] state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_q, last_d;
  logic [3:0] cnt_q, cnt_d;
  logic       gnt0_q, gnt0_d;
  logic       gnt1_q, gnt1_d;
  logic       cs0_n_q, cs0_n_d;
  logic       cs1_n_q, cs1_n_d;
  logic       done_q, done_d;
  logic [7:0] rdata_q, rdata_d;
  logic       start_q, start_d;
  logic [7:0] din_q, din_d;

  logic       req_own;
  logic       xfer_own;
  logic [7:0] wdata_own;

  // Owner-side view of the request interface
  always_comb begin
    req_own   = owner_q ? req1 : req0;
    xfer_own  = owner_q ? xfer1 : xfer0;
    wdata_own = owner_q ? wdata1 : wdata0;
  end

  // Arbitration FSM: grant, CS setup, byte handshake with the engine, CS guard
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    gnt0_d  = gnt0_q;
    gnt1_d  = gnt1_q;
    cs0_n_d = cs0_n_q;
    cs1_n_d = cs1_n_q;
    done_d  = 1'b0;
    rdata_d = rdata_q;
    start_d = 1'b0;
    din_d   = din_q;
    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          // On a tie the port not served last wins
          if (req0 && req1) owner_d = ~last_q;
          else              owner_d = req1;
          gnt0_d  = ~owner_d;
          gnt1_d  = owner_d;
          cs0_n_d = owner_d;
          cs1_n_d = ~owner_d;
          cnt_d   = SETUP_LOAD;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == 4'd0) state_d = ST_READY;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_READY: begin
        // Release takes priority over a byte strobe in the same cycle
        if (!req_own) begin
          gnt0_d  = 1'b0;
          gnt1_d  = 1'b0;
          cs0_n_d = 1'b1;
          cs1_n_d = 1'b1;
          cnt_d   = GUARD_LOAD;
          state_d = ST_GUARD;
        end else if (xfer_own) begin
          din_d   = wdata_own;
          start_d = 1'b1;
          state_d = ST_WAIT_HI;
        end
      end
      ST_WAIT_HI: begin
        if (spi_busy) state_d = ST_WAIT_LO;
      end
      ST_WAIT_LO: begin
        if (!spi_busy) begin
          rdata_d = spi_dout;
          done_d  = 1'b1;
          state_d = ST_READY;
        end
      end
      ST_GUARD: begin
        if (cnt_q == 4'd0) begin
          last_d  = owner_q;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= 4'd0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      cs0_n_q <= 1'b1;
      cs1_n_q <= 1'b1;
      done_q  <= 1'b0;
      rdata_q <= 8'd0;
      start_q <= 1'b0;
      din_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      cs0_n_q <= cs0_n_d;
      cs1_n_q <= cs1_n_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      start_q <= start_d;
      din_q   <= din_d;
    end
  end

  // Divisor follows the owner, which only changes when a grant is issued from IDLE
  always_comb begin
    spi_divisor = owner_q ? div1 : div0;
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign cs0_n     = cs0_n_q;
  assign cs1_n     = cs1_n_q;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign spi_start = start_q;
  assign spi_din   = din_q;

endmodule
